// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the block-reduce MAC slice.
//   - mac_state_e : reduce controller states
//   - MAC_DATA_W  : default width of a streamed MAC result word
//   - MAC_NUM_WORDS : default number of words per block-read burst
//   - MAC_IDX_W   : width of word index / counter (covers up to 64 words)
//   - MAC_SUM_EXT : extra sum bits so 64 full-scale words cannot overflow
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } mac_state_e;

  localparam int MAC_DATA_W    = 32;
  localparam int MAC_NUM_WORDS = 64;
  localparam int MAC_IDX_W     = 6;
  localparam int MAC_SUM_EXT   = 6;

endpackage

// File: rtl/mac_block_reduce_if.sv
// mac_block_reduce_if: handshake and result bus of mac_block_reduce.
//   Requests   : EN_reduce / RDY_reduce (start), RDY_blockRead / EN_blockRead
//   Stream     : VALID_memVal, memVal_data
//   Result     : VALID_result, EN_resultAck, res_sum, res_max, res_max_idx, res_min
//   master modport = environment side, slave modport = reducer side.
interface mac_block_reduce_if
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W
);
  logic                          EN_reduce;
  logic                          RDY_reduce;
  logic                          RDY_blockRead;
  logic                          EN_blockRead;
  logic                          VALID_memVal;
  logic [DATA_W-1:0]             memVal_data;
  logic                          VALID_result;
  logic                          EN_resultAck;
  logic [DATA_W+MAC_SUM_EXT-1:0] res_sum;
  logic [DATA_W-1:0]             res_max;
  logic [MAC_IDX_W-1:0]          res_max_idx;
  logic [DATA_W-1:0]             res_min;

  modport master (
    output EN_reduce, RDY_blockRead, VALID_memVal, memVal_data, EN_resultAck,
    input  RDY_reduce, EN_blockRead, VALID_result, res_sum, res_max, res_max_idx, res_min
  );

  modport slave (
    input  EN_reduce, RDY_blockRead, VALID_memVal, memVal_data, EN_resultAck,
    output RDY_reduce, EN_blockRead, VALID_result, res_sum, res_max, res_max_idx, res_min
  );
endinterface

// File: rtl/mac_reduce_dp.sv
// mac_reduce_dp: running sum / max / min datapath for one block.
//   clk, rst_n : clock, asynchronous active-low reset (all outputs to zero)
//   clear      : start of a new block (sum=0, max=0, idx=0, min=all-ones)
//   accept     : fold word (at index idx) into the running results
//   sum, max_val, max_idx, min_val : registered results, held between blocks
module mac_reduce_dp
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          accept,
  input  logic [DATA_W-1:0]             word,
  input  logic [MAC_IDX_W-1:0]          idx,
  output logic [DATA_W+MAC_SUM_EXT-1:0] sum,
  output logic [DATA_W-1:0]             max_val,
  output logic [MAC_IDX_W-1:0]          max_idx,
  output logic [DATA_W-1:0]             min_val
);
  localparam int SUM_W = DATA_W + MAC_SUM_EXT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      max_val <= '0;
      max_idx <= '0;
      min_val <= '0;
    end else if (clear) begin
      sum     <= '0;
      max_val <= '0;
      max_idx <= '0;
      min_val <= '1;
    end else if (accept) begin
      sum <= sum + SUM_W'(word);
      // Strict compares: on ties the earliest index is kept.
      if (word > max_val) begin
        max_val <= word;
        max_idx <= idx;
      end
      if (word < min_val) begin
        min_val <= word;
      end
    end
  end
endmodule

// File: rtl/mac_block_reduce.sv
// mac_block_reduce: requests one block read from the MAC, reduces the
// streamed words to sum / max (with index) / min, and presents the result
// until acknowledged.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : mac_block_reduce_if.slave (start, block-read, stream, result)
// Parameters: NUM_WORDS (power of two, 2..64), DATA_W (word width).
module mac_block_reduce
  import mac_pkg::*;
#(
  parameter int NUM_WORDS = MAC_NUM_WORDS,
  parameter int DATA_W    = MAC_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  mac_block_reduce_if.slave bus
);
  localparam logic [MAC_IDX_W-1:0] LAST_IDX = MAC_IDX_W'(NUM_WORDS - 1);

  mac_state_e           state_reg, state_next;
  logic [MAC_IDX_W-1:0] count_reg;
  logic                 start;
  logic                 accept;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        count_reg <= '0;
      end else if (accept) begin
        // Wraps to zero after the last word of a 64-word block; harmless
        // because the next start clears it anyway.
        count_reg <= count_reg + MAC_IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.EN_reduce) begin
          start      = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.RDY_blockRead) begin
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (bus.VALID_memVal) begin
          accept = 1'b1;
          if (count_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.EN_resultAck) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.RDY_reduce   = (state_reg == ST_IDLE);
  // Request is issued in the same cycle the MAC reports ready, so it is a
  // single-cycle pulse: that edge moves the controller on to COLLECT.
  assign bus.EN_blockRead = (state_reg == ST_REQ) && bus.RDY_blockRead;
  assign bus.VALID_result = (state_reg == ST_DONE);

  mac_reduce_dp #(
    .DATA_W (DATA_W)
  ) u_dp (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clear   (start),
    .accept  (accept),
    .word    (bus.memVal_data),
    .idx     (count_reg),
    .sum     (bus.res_sum),
    .max_val (bus.res_max),
    .max_idx (bus.res_max_idx),
    .min_val (bus.res_min)
  );
endmodule

// File: tb/tb_mac_block_reduce.sv
// tb_mac_block_reduce: directed self-checking bench for mac_block_reduce
// (64 words of 32 bits). Expected values are hand-computed constants.
module tb_mac_block_reduce;
  import mac_pkg::*;

  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_errors;
  logic [31:0] words [64];

  mac_block_reduce_if #(.DATA_W(32)) bus ();

  mac_block_reduce #(
    .NUM_WORDS (64),
    .DATA_W    (32)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_res(input string tag, input logic [37:0] sum, input logic [31:0] mx,
                           input logic [5:0] mx_idx, input logic [31:0] mn);
    check({tag, "_sum"}, bus.res_sum, sum);
    check({tag, "_max"}, bus.res_max, mx);
    check({tag, "_max_idx"}, bus.res_max_idx, mx_idx);
    check({tag, "_min"}, bus.res_min, mn);
  endtask

  // Start a block: EN_reduce pulse, stray words while IDLE/REQ, MAC ready
  // held low for hold_low cycles, then a single block-read request.
  task automatic start_block(input int hold_low);
    int waited = 0;
    bit en_seen = 1'b0;
    while (!bus.RDY_reduce && waited < 20) begin
      tick();
      waited++;
    end
    check("rdy_before_start", bus.RDY_reduce, 1);
    bus.EN_reduce    = 1'b1;
    bus.VALID_memVal = 1'b1;
    bus.memVal_data  = 32'd1000;
    tick();
    bus.EN_reduce = 1'b0;
    check("start_clear_sum", bus.res_sum, 0);
    check("start_clear_min", bus.res_min, 32'hFFFF_FFFF);
    check("rdy_low_in_req", bus.RDY_reduce, 0);
    for (int i = 0; i < hold_low; i++) begin
      if (bus.EN_blockRead) en_seen = 1'b1;
      tick();
    end
    check("blockread_held_low", en_seen, 0);
    bus.RDY_blockRead = 1'b1;
    #1;
    check("blockread_pulse", bus.EN_blockRead, 1);
    tick();
    check("blockread_single", bus.EN_blockRead, 0);
    bus.RDY_blockRead = 1'b0;
    bus.VALID_memVal  = 1'b0;
  endtask

  // Stream words[0..n-1]; with gaps, an idle cycle carrying junk data is
  // inserted before every third word.
  task automatic feed(input bit gaps, input int n, input bit expect_done);
    bit early = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 2)) begin
        bus.VALID_memVal = 1'b0;
        bus.memVal_data  = 32'hA5A5_A5A5;
        tick();
        if (bus.VALID_result) early = 1'b1;
      end
      bus.VALID_memVal = 1'b1;
      bus.memVal_data  = words[i];
      tick();
      if (i < n - 1 && bus.VALID_result) early = 1'b1;
    end
    bus.VALID_memVal = 1'b0;
    check("no_early_valid", early, 0);
    if (expect_done) check("valid_after_last", bus.VALID_result, 1);
  endtask

  task automatic ack();
    bus.EN_resultAck = 1'b1;
    tick();
    bus.EN_resultAck = 1'b0;
    check("ack_rdy", bus.RDY_reduce, 1);
    check("ack_valid_low", bus.VALID_result, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST_N             = 1'b0;
    bus.EN_reduce     = 1'b0;
    bus.RDY_blockRead = 1'b0;
    bus.VALID_memVal  = 1'b0;
    bus.memVal_data   = '0;
    bus.EN_resultAck  = 1'b0;
    #2;
    check("rst_rdy", bus.RDY_reduce, 1);
    check("rst_en_blockread", bus.EN_blockRead, 0);
    check("rst_valid", bus.VALID_result, 0);
    check_res("rst", 38'd0, 32'd0, 6'd0, 32'd0);
    repeat (3) tick();
    RST_N = 1'b1;
    tick();

    // Ramp 0..63, no gaps.
    for (int i = 0; i < 64; i++) words[i] = 32'(i);
    start_block(0);
    feed(1'b0, 64, 1'b1);
    check_res("ramp", 38'd2016, 32'd63, 6'd63, 32'd0);
    // Words in DONE must be ignored.
    bus.VALID_memVal = 1'b1;
    bus.memVal_data  = 32'hFFFF_FFFF;
    repeat (3) tick();
    bus.VALID_memVal = 1'b0;
    check_res("done_hold", 38'd2016, 32'd63, 6'd63, 32'd0);
    check("done_rdy_low", bus.RDY_reduce, 0);
    ack();
    check("kept_after_ack", bus.res_sum, 38'd2016);

    // All ones.
    for (int i = 0; i < 64; i++) words[i] = 32'hFFFF_FFFF;
    start_block(0);
    feed(1'b0, 64, 1'b1);
    check_res("ones", 38'h3F_FFFF_FFC0, 32'hFFFF_FFFF, 6'd0, 32'hFFFF_FFFF);
    bus.EN_reduce = 1'b1;
    tick();
    bus.EN_reduce = 1'b0;
    check("done_ignores_start", bus.VALID_result, 1);
    ack();

    // Duplicate maximum with gaps, MAC ready delayed 10 cycles.
    // Sum = 62*7 + 2*500 = 1434.
    for (int i = 0; i < 64; i++) words[i] = 32'd7;
    words[5]  = 32'd500;
    words[40] = 32'd500;
    start_block(10);
    feed(1'b1, 64, 1'b1);
    check_res("dup", 38'd1434, 32'd500, 6'd5, 32'd7);
    ack();

    // Reset in the middle of a block, then a full block of ones.
    for (int i = 0; i < 64; i++) words[i] = 32'd9;
    start_block(0);
    feed(1'b0, 31, 1'b0);
    bus.RDY_blockRead = 1'b1;
    RST_N = 1'b0;
    #1;
    check("midrst_sum", bus.res_sum, 0);
    check("midrst_valid", bus.VALID_result, 0);
    check("midrst_rdy", bus.RDY_reduce, 1);
    check("midrst_en_blockread", bus.EN_blockRead, 0);
    tick();
    bus.RDY_blockRead = 1'b0;
    RST_N = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) words[i] = 32'd1;
    start_block(0);
    feed(1'b0, 64, 1'b1);
    check_res("after_rst", 38'd64, 32'd1, 6'd0, 32'd1);

    // Ack and start together in DONE: back to IDLE without a new request.
    bus.EN_resultAck = 1'b1;
    bus.EN_reduce    = 1'b1;
    tick();
    bus.EN_resultAck  = 1'b0;
    bus.EN_reduce     = 1'b0;
    bus.RDY_blockRead = 1'b1;
    #1;
    check("both_rdy", bus.RDY_reduce, 1);
    check("both_no_request", bus.EN_blockRead, 0);
    tick();
    bus.RDY_blockRead = 1'b0;
    check("both_still_idle", bus.RDY_reduce, 1);
    // Fresh block 64 down to 1: sum 2080, max 64 at index 0, min 1.
    for (int i = 0; i < 64; i++) words[i] = 32'(64 - i);
    start_block(0);
    feed(1'b0, 64, 1'b1);
    check_res("fresh", 38'd2080, 32'd64, 6'd0, 32'd1);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
